// File: rtl/axi_sw_pkg.sv
// Shared types and default constants for the switch-driven AXI-lite command master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_sw_pkg;

  // Handshake FSM states: idle, read address phase, read data phase, write (aw + w) phase.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } state_t;

  localparam int ADDR_W_DEF          = 4;
  localparam int DATA_W_DEF          = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int TIMEOUT_CYCLES_DEF  = 32;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, debounce filter, one-cycle rising-edge pulse.
// Latency: rise pulse 2 sync cycles + DEBOUNCE_CYCLES stable cycles + 1 after the raw edge.
// Backpressure: none; the pulse is fire-and-forget and the consumer may drop it.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  logic w_diff;
  logic w_flip;

  // The accepted level only moves once the synced input has disagreed with it for
  // DEBOUNCE_CYCLES consecutive cycles; the counter never runs past its terminal value.
  assign w_diff = (r_sync1 != r_level);
  assign w_flip = w_diff && (r_cnt == TERM);

  // Synchronise the raw button, run the stability counter and flag 0->1 level changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= i_btn;
      r_sync1 <= r_sync0;
      r_rise  <= w_flip && r_sync1;
      if (w_flip) begin
        r_level <= r_sync1;
        r_cnt   <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/axi_switch_master.sv
// Launches one AXI-lite read or write per debounced button press, address/data from switches.
// Latency: valid rises the cycle after the debounced request; done pulses the cycle after the last beat.
// Backpressure: waits on slave ready/valid; aborts after TIMEOUT_CYCLES stalled; presses while busy dropped.
module axi_switch_master
  import axi_sw_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              btn_rd,
  input  logic              btn_wr,
  output logic [ADDR_W-1:0] SWM_arADDR,
  output logic [DATA_W-1:0] SWM_wdata,
  output logic              ms_arvalid,
  input  logic              sm_arready,
  output logic              ms_rready,
  input  logic              sm_rvalid,
  output logic              ms_awvalid,
  input  logic              sm_awready,
  output logic              ms_wvalid,
  input  logic              sm_wready,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_TERM = TW'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_aw_done;
  logic              r_w_done;
  logic [TW-1:0]     r_tmo_cnt;
  logic              r_done;
  logic              r_terr;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic              w_aw_done_nxt;
  logic              w_w_done_nxt;
  logic [TW-1:0]     w_tmo_nxt;
  logic              w_done_nxt;
  logic              w_terr_nxt;

  logic w_rd_req;
  logic w_wr_req;
  logic w_ar_beat;
  logic w_r_beat;
  logic w_aw_beat;
  logic w_w_beat;
  logic w_tmo_hit;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rd (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_rd),
    .o_rise (w_rd_req)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_wr (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_wr),
    .o_rise (w_wr_req)
  );

  // Handshake outputs are pure functions of registered state, so they hold until their beat.
  assign ms_arvalid  = (r_state == RD_ADDR);
  assign ms_rready   = (r_state == RD_DATA);
  assign ms_awvalid  = (r_state == WR) && !r_aw_done;
  assign ms_wvalid   = (r_state == WR) && !r_w_done;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign timeout_err = r_terr;
  assign SWM_arADDR  = r_addr;
  assign SWM_wdata   = r_wdata;

  assign w_ar_beat = ms_arvalid && sm_arready;
  assign w_r_beat  = ms_rready  && sm_rvalid;
  assign w_aw_beat = ms_awvalid && sm_awready;
  assign w_w_beat  = ms_wvalid  && sm_wready;
  assign w_tmo_hit = (r_tmo_cnt == TMO_TERM);

  // Next-state logic: launch from IDLE (read wins a tie), advance on beats, abort on stall timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_aw_done_nxt = r_aw_done | w_aw_beat;
    w_w_done_nxt  = r_w_done  | w_w_beat;
    w_tmo_nxt     = w_tmo_hit ? r_tmo_cnt : r_tmo_cnt + TW'(1);
    w_done_nxt    = 1'b0;
    w_terr_nxt    = r_terr;
    unique case (r_state)
      IDLE: begin
        w_tmo_nxt     = '0;
        w_aw_done_nxt = 1'b0;
        w_w_done_nxt  = 1'b0;
        if (w_rd_req) begin
          w_state_nxt = RD_ADDR;
          w_addr_nxt  = sw_addr;
          w_terr_nxt  = 1'b0;
        end else if (w_wr_req) begin
          w_state_nxt = WR;
          w_addr_nxt  = sw_addr;
          w_wdata_nxt = sw_data;
          w_terr_nxt  = 1'b0;
        end
      end
      RD_ADDR: begin
        if (w_ar_beat) begin
          w_state_nxt = RD_DATA;
          w_tmo_nxt   = '0;
        end else if (w_tmo_hit) begin
          w_state_nxt = IDLE;
          w_terr_nxt  = 1'b1;
        end
      end
      RD_DATA: begin
        if (w_r_beat) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt = IDLE;
          w_terr_nxt  = 1'b1;
        end
      end
      WR: begin
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_aw_beat || w_w_beat) begin
          w_tmo_nxt = '0;
        end else if (w_tmo_hit) begin
          w_state_nxt = IDLE;
          w_terr_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and capture registers; reset returns everything to idle with outputs low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_tmo_cnt <= '0;
      r_done    <= 1'b0;
      r_terr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
      r_tmo_cnt <= w_tmo_nxt;
      r_done    <= w_done_nxt;
      r_terr    <= w_terr_nxt;
    end
  end

endmodule
